// File: rtl/frame_tail_checker.sv
// Frame tail checker: after an EOF_Flag strobe, checks the End-of-Frame
// field (EOF_LEN recessive bits) and the intermission (IFS_LEN recessive
// bits) on RX. It reports form errors, overload conditions, an early SOF
// in the last intermission bit, and a clean frame completion.
//
// Handshake: there is no valid/ready pair. RX is treated as valid on every
// rising SP edge. EOF_Flag is a single-edge start strobe that is always
// accepted, with no ready and no back-pressure. A strobe on any edge
// restarts the check from EOF bit 0, and RX on that strobe edge is ignored.
module frame_tail_checker #(
    parameter int EOF_LEN       = 7,
    parameter int IFS_LEN       = 3,
    parameter bit LAST_EOF_OVLD = 1'b1
) (
    input  logic       SP,
    input  logic       reset,
    input  logic       RX,
    input  logic       EOF_Flag,
    output logic       EOF_Error,
    output logic       Overload_Flag,
    output logic       SOF_Detect,
    output logic       Frame_Done,
    output logic       Bus_Idle,
    output logic       Busy,
    output logic [3:0] Bit_Cnt,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_LEN - 1);
    localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EOF  = 2'd1,
        ST_IFS  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_n;
    logic             eof_err_n, ovld_n, sof_n, done_n, bus_idle_n, busy_n;

    // The encoded state is exposed so checkers can follow the FSM directly.
    assign state_dbg = state;

    // State and output registers; every output is a flop.
    always_ff @(posedge SP) begin
        if (reset) begin
            state         <= ST_IDLE;
            Bit_Cnt       <= '0;
            EOF_Error     <= 1'b0;
            Overload_Flag <= 1'b0;
            SOF_Detect    <= 1'b0;
            Frame_Done    <= 1'b0;
            Bus_Idle      <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            state         <= state_n;
            Bit_Cnt       <= cnt_n;
            EOF_Error     <= eof_err_n;
            Overload_Flag <= ovld_n;
            SOF_Detect    <= sof_n;
            Frame_Done    <= done_n;
            Bus_Idle      <= bus_idle_n;
            Busy          <= busy_n;
        end
    end

    // Next-state, next-count and next-output decode for the bit checker.
    always_comb begin
        state_n    = state;
        cnt_n      = Bit_Cnt;
        eof_err_n  = EOF_Error;
        bus_idle_n = Bus_Idle;
        ovld_n     = 1'b0;
        sof_n      = 1'b0;
        done_n     = 1'b0;

        if (EOF_Flag) begin
            // A restart discards any partial progress and clears the levels.
            state_n    = ST_EOF;
            cnt_n      = '0;
            eof_err_n  = 1'b0;
            bus_idle_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_n = '0;
                end
                ST_EOF: begin
                    if (!RX) begin
                        cnt_n = '0;
                        if (Bit_Cnt == EOF_LAST && LAST_EOF_OVLD) begin
                            // A dominant last EOF bit starts an overload frame.
                            ovld_n  = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            eof_err_n = 1'b1;
                            state_n   = ST_ERR;
                        end
                    end else if (Bit_Cnt == EOF_LAST) begin
                        cnt_n   = '0;
                        state_n = ST_IFS;
                    end else begin
                        cnt_n = Bit_Cnt + 4'd1;
                    end
                end
                ST_IFS: begin
                    if (!RX) begin
                        cnt_n   = '0;
                        state_n = ST_IDLE;
                        // A dominant last intermission bit is read as a new SOF.
                        if (Bit_Cnt == IFS_LAST) begin
                            sof_n = 1'b1;
                        end else begin
                            ovld_n = 1'b1;
                        end
                    end else if (Bit_Cnt == IFS_LAST) begin
                        cnt_n      = '0;
                        done_n     = 1'b1;
                        bus_idle_n = 1'b1;
                        state_n    = ST_IDLE;
                    end else begin
                        cnt_n = Bit_Cnt + 4'd1;
                    end
                end
                ST_ERR: begin
                    // RX is ignored until the next strobe or reset.
                    cnt_n     = '0;
                    eof_err_n = 1'b1;
                end
                default: begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end
            endcase
        end

        busy_n = (state_n == ST_EOF) || (state_n == ST_IFS);
    end

endmodule

// File: tb/tb_frame_tail_checker.sv
// Testbench for frame_tail_checker. Three instances share one stimulus
// stream: the default configuration, one with LAST_EOF_OVLD=0, and one
// with EOF_LEN=10/IFS_LEN=2. Expected output vectors are queued before
// each edge and compared after it.
module tb_frame_tail_checker;

    localparam int W = 10;

    // ---------------- clock / reset ----------------
    logic SP = 1'b0;
    logic reset;
    logic RX;
    logic EOF_Flag;

    always #5 SP = ~SP;

    logic       a_err, a_ovl, a_sof, a_done, a_idle, a_busy;
    logic [3:0] a_cnt;
    logic [1:0] a_st;
    logic       b_err, b_ovl, b_sof, b_done, b_idle, b_busy;
    logic [3:0] b_cnt;
    logic [1:0] b_st;
    logic       c_err, c_ovl, c_sof, c_done, c_idle, c_busy;
    logic [3:0] c_cnt;
    logic [1:0] c_st;

    frame_tail_checker #(.EOF_LEN(7), .IFS_LEN(3), .LAST_EOF_OVLD(1'b1)) dut_a (
        .SP(SP), .reset(reset), .RX(RX), .EOF_Flag(EOF_Flag),
        .EOF_Error(a_err), .Overload_Flag(a_ovl), .SOF_Detect(a_sof),
        .Frame_Done(a_done), .Bus_Idle(a_idle), .Busy(a_busy),
        .Bit_Cnt(a_cnt), .state_dbg(a_st)
    );

    frame_tail_checker #(.EOF_LEN(7), .IFS_LEN(3), .LAST_EOF_OVLD(1'b0)) dut_b (
        .SP(SP), .reset(reset), .RX(RX), .EOF_Flag(EOF_Flag),
        .EOF_Error(b_err), .Overload_Flag(b_ovl), .SOF_Detect(b_sof),
        .Frame_Done(b_done), .Bus_Idle(b_idle), .Busy(b_busy),
        .Bit_Cnt(b_cnt), .state_dbg(b_st)
    );

    frame_tail_checker #(.EOF_LEN(10), .IFS_LEN(2), .LAST_EOF_OVLD(1'b1)) dut_c (
        .SP(SP), .reset(reset), .RX(RX), .EOF_Flag(EOF_Flag),
        .EOF_Error(c_err), .Overload_Flag(c_ovl), .SOF_Detect(c_sof),
        .Frame_Done(c_done), .Bus_Idle(c_idle), .Busy(c_busy),
        .Bit_Cnt(c_cnt), .state_dbg(c_st)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;

    // Output vector: {err, ovl, sof, done, idle, busy, cnt[3:0]}
    function automatic logic [W-1:0] mk(input bit err, input bit ovl, input bit sof,
                                        input bit done, input bit idle, input bit busy,
                                        input logic [3:0] cnt);
        return {err, ovl, sof, done, idle, busy, cnt};
    endfunction

    function automatic logic [W-1:0] obs_of(input int which);
        case (which)
            0:       return {a_err, a_ovl, a_sof, a_done, a_idle, a_busy, a_cnt};
            1:       return {b_err, b_ovl, b_sof, b_done, b_idle, b_busy, b_cnt};
            default: return {c_err, c_ovl, c_sof, c_done, c_idle, c_busy, c_cnt};
        endcase
    endfunction

    task automatic push_exp(input int which, input string tag, input logic [W-1:0] vec);
        exp_q.push_back(vec);
        sel_q.push_back(which);
        tag_q.push_back(tag);
    endtask

    // ---------------- driver ----------------
    // Drive inputs, take one SP edge, then check everything queued for it.
    task automatic step(input logic rx, input logic flag, input logic rst);
        logic [W-1:0] vec;
        logic [W-1:0] got;
        int           w;
        string        t;
        RX       = rx;
        EOF_Flag = flag;
        reset    = rst;
        @(posedge SP);
        #1;
        while (exp_q.size() > 0) begin
            vec = exp_q.pop_front();
            w   = sel_q.pop_front();
            t   = tag_q.pop_front();
            got = obs_of(w);
            checks++;
            assert (got === vec) else begin
                errors++;
                $error("FAIL %s dut%0d: observed %b expected %b", t, w, got, vec);
            end
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        RX       = 1'b1;
        EOF_Flag = 1'b0;

        // reset state, all instances
        for (int i = 0; i < 2; i++) begin
            push_exp(0, "reset", mk(0, 0, 0, 0, 0, 0, 4'd0));
            push_exp(1, "reset", mk(0, 0, 0, 0, 0, 0, 4'd0));
            push_exp(2, "reset", mk(0, 0, 0, 0, 0, 0, 4'd0));
            step(1'b1, 1'b1, 1'b1);
        end

        // no events before the first strobe
        for (int i = 0; i < 4; i++) begin
            push_exp(0, "quiet", mk(0, 0, 0, 0, 0, 0, 4'd0));
            step(rnd(), 1'b0, 1'b0);
        end

        // clean frame; RX on the strobe edge is dominant and must be ignored
        push_exp(0, "clean_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            push_exp(0, "clean_eof", mk(0, 0, 0, 0, 0, 1, (i == 6) ? 4'd0 : 4'(i + 1)));
            step(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            push_exp(0, "clean_ifs", mk(0, 0, 0, 0, 0, 1, 4'(i + 1)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(0, "clean_done", mk(0, 0, 0, 1, 1, 0, 4'd0));
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_exp(0, "idle_hold", mk(0, 0, 0, 0, 1, 0, 4'd0));
            step(rnd(), 1'b0, 1'b0);
        end

        // form error at EOF index 2, sticky for 20 edges
        push_exp(0, "form_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            push_exp(0, "form_eof", mk(0, 0, 0, 0, 0, 1, 4'(i + 1)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(0, "form_err", mk(1, 0, 0, 0, 0, 0, 4'd0));
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            push_exp(0, "err_sticky", mk(1, 0, 0, 0, 0, 0, 4'd0));
            step(rnd(), 1'b0, 1'b0);
        end

        // dominant last EOF bit: overload on dut_a, error on dut_b
        push_exp(0, "ovl_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        push_exp(1, "ovl_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            push_exp(0, "ovl_eof", mk(0, 0, 0, 0, 0, 1, 4'(i + 1)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(0, "last_ovl", mk(0, 1, 0, 0, 0, 0, 4'd0));
        push_exp(1, "last_err", mk(1, 0, 0, 0, 0, 0, 4'd0));
        step(1'b0, 1'b0, 1'b0);
        push_exp(0, "ovl_single", mk(0, 0, 0, 0, 0, 0, 4'd0));
        push_exp(1, "err_hold", mk(1, 0, 0, 0, 0, 0, 4'd0));
        step(1'b1, 1'b0, 1'b0);

        // dominant IFS index 1: overload
        push_exp(0, "ifs1_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            push_exp(0, "ifs1_eof", mk(0, 0, 0, 0, 0, 1, (i == 6) ? 4'd0 : 4'(i + 1)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(0, "ifs1_bit0", mk(0, 0, 0, 0, 0, 1, 4'd1));
        step(1'b1, 1'b0, 1'b0);
        push_exp(0, "ifs1_ovl", mk(0, 1, 0, 0, 0, 0, 4'd0));
        step(1'b0, 1'b0, 1'b0);

        // dominant IFS index 2: SOF, bus not idle
        push_exp(0, "sof_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            push_exp(0, "sof_bits", mk(0, 0, 0, 0, 0, 1, (i < 6) ? 4'(i + 1) : 4'(i - 6)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(0, "sof_pulse", mk(0, 0, 1, 0, 0, 0, 4'd0));
        step(1'b0, 1'b0, 1'b0);
        push_exp(0, "sof_after", mk(0, 0, 0, 0, 0, 0, 4'd0));
        step(1'b1, 1'b0, 1'b0);

        // restart at EOF index 4, then a full clean sequence
        push_exp(0, "rst_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_exp(0, "rst_eof", mk(0, 0, 0, 0, 0, 1, 4'(i + 1)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(0, "restart", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            push_exp(0, "restart_bits", mk(0, 0, 0, 0, 0, 1, (i < 6) ? 4'(i + 1) : 4'(i - 6)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(0, "restart_done", mk(0, 0, 0, 1, 1, 0, 4'd0));
        step(1'b1, 1'b0, 1'b0);

        // reset at IFS index 1, with a strobe on the same edge
        push_exp(0, "mid_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push_exp(0, "mid_bits", mk(0, 0, 0, 0, 0, 1, (i < 6) ? 4'(i + 1) : 4'(i - 6)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(0, "mid_reset", mk(0, 0, 0, 0, 0, 0, 4'd0));
        push_exp(1, "mid_reset", mk(0, 0, 0, 0, 0, 0, 4'd0));
        push_exp(2, "mid_reset", mk(0, 0, 0, 0, 0, 0, 4'd0));
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push_exp(0, "post_reset", mk(0, 0, 0, 0, 0, 0, 4'd0));
            push_exp(2, "post_reset", mk(0, 0, 0, 0, 0, 0, 4'd0));
            step(rnd(), 1'b0, 1'b0);
        end

        // EOF_LEN=10, IFS_LEN=2: Frame_Done 12 edges after the strobe
        push_exp(2, "sweep_start", mk(0, 0, 0, 0, 0, 1, 4'd0));
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push_exp(2, "sweep_eof", mk(0, 0, 0, 0, 0, 1, (i == 9) ? 4'd0 : 4'(i + 1)));
            step(1'b1, 1'b0, 1'b0);
        end
        push_exp(2, "sweep_ifs", mk(0, 0, 0, 0, 0, 1, 4'd1));
        step(1'b1, 1'b0, 1'b0);
        push_exp(2, "sweep_done", mk(0, 0, 0, 1, 1, 0, 4'd0));
        step(1'b1, 1'b0, 1'b0);
        push_exp(2, "sweep_idle", mk(0, 0, 0, 0, 1, 0, 4'd0));
        step(1'b0, 1'b0, 1'b0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_tail_checker.md
FRAME_TAIL_CHECKER -- requirements
Module: frame_tail_checker

Interface
REQ-001 The block SHALL have one clock, SP, and a synchronous, active-high reset, reset.
REQ-002 Parameter EOF_LEN, default 7: number of End-of-Frame bits checked; legal range 2..15.
REQ-003 Parameter IFS_LEN, default 3: number of intermission bits checked; legal range 2..15.
REQ-004 Parameter LAST_EOF_OVLD, default 1: when 1, a dominant last EOF bit is an overload condition, not an error.
REQ-005 Port list (CNT_W = 4):
- SP  input  1: sample-point clock; RX is sampled on each rising edge.
- reset  input  1: synchronous reset.
- RX  input  1: bus bit; 0 = dominant, 1 = recessive.
- EOF_Flag  input  1: start strobe; EOF checking begins on the next edge.
- EOF_Error  output  1: form error seen in EOF; sticky.
- Overload_Flag  output  1: one-cycle pulse on an overload condition.
- SOF_Detect  output  1: one-cycle pulse when a dominant last intermission bit is seen.
- Frame_Done  output  1: one-cycle pulse when EOF and intermission both complete clean.
- Bus_Idle  output  1: level; high after a clean completion.
- Busy  output  1: high while in EOF or IFS.
- Bit_Cnt  output  CNT_W: index of the next bit to sample within the current field.

Function
REQ-006 States SHALL be IDLE, EOF, IFS and ERR; all outputs are registered.
REQ-007 An edge with EOF_Flag=1 SHALL, in any state, move to EOF with Bit_Cnt=0 and clear EOF_Error and Bus_Idle. That edge's RX is not checked.
REQ-008 In EOF, each edge SHALL sample RX as EOF bit Bit_Cnt, then increment Bit_Cnt.
REQ-009 A dominant EOF bit at index 0..EOF_LEN-2 SHALL:
- set EOF_Error on that same edge;
- move to ERR.
REQ-010 A dominant EOF bit at index EOF_LEN-1 SHALL:
- when LAST_EOF_OVLD=1, pulse Overload_Flag and move to IDLE;
- when LAST_EOF_OVLD=0, behave as REQ-009.
REQ-011 A recessive EOF bit at index EOF_LEN-1 SHALL move to IFS with Bit_Cnt=0.
REQ-012 In IFS, a dominant bit at index 0..IFS_LEN-2 SHALL pulse Overload_Flag and move to IDLE.
REQ-013 In IFS, a dominant bit at index IFS_LEN-1 SHALL pulse SOF_Detect and move to IDLE; Bus_Idle stays 0.
REQ-014 A recessive bit at IFS index IFS_LEN-1 SHALL:
- pulse Frame_Done;
- set Bus_Idle;
- move to IDLE.
REQ-015 ERR SHALL hold EOF_Error=1 and ignore RX until EOF_Flag or reset.
REQ-016 Busy SHALL be 1 exactly while the state is EOF or IFS.
REQ-017 Bit_Cnt SHALL be 0 in IDLE and ERR, and SHALL never exceed max(EOF_LEN, IFS_LEN)-1.
REQ-018 Overload_Flag, SOF_Detect and Frame_Done SHALL each be high for exactly one SP cycle per event, and never simultaneously.
REQ-019 EOF_Flag arriving during EOF or IFS SHALL restart the check per REQ-007 and discard partial progress.
REQ-020 Bus_Idle SHALL remain high in IDLE regardless of RX until the next EOF_Flag or reset.

Reset
REQ-021 reset=1 at an edge SHALL force IDLE, Bit_Cnt=0 and all outputs 0, including mid-EOF or IFS and in ERR.
REQ-022 reset SHALL take priority over EOF_Flag on the same edge.
REQ-023 After reset deasserts, no event output SHALL assert until an EOF_Flag has been taken.

Verification
REQ-024 Clean frame (defaults): EOF_Flag pulse, then 7+3 recessive bits -> Frame_Done pulse on the 10th edge after the strobe; Bus_Idle=1; EOF_Error=0.
REQ-025 Form error: EOF_Flag, 2 recessive bits, then RX=0 at EOF index 2 -> EOF_Error=1 on that edge, Busy=0; EOF_Error stays 1 for 20 further edges until EOF_Flag clears it.
REQ-026 Last-bit overload: RX=0 only at EOF index 6 -> Overload_Flag one pulse, EOF_Error=0; repeat with LAST_EOF_OVLD=0 -> EOF_Error=1.
REQ-027 Intermission: RX=0 at IFS index 1 -> Overload_Flag pulse. RX=0 at IFS index 2 -> SOF_Detect pulse, Bus_Idle=0.
REQ-028 Restart and reset: EOF_Flag at EOF index 4 -> Bit_Cnt returns to 0 and a full clean sequence follows. reset at IFS index 1 -> all outputs 0 on the next cycle.
REQ-029 Parameter sweep: EOF_LEN=10, IFS_LEN=2, clean sequence -> Frame_Done exactly 12 edges after EOF_Flag.
